// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared volume width and sequencer state encoding
package synth_pkg;

    localparam int VOL_W = 7;

    typedef enum logic [1:0] {
        WAIT_DAC = 2'd0,
        IDLE     = 2'd1,
        RAMP     = 2'd2
    } seq_state_e;

endpackage

// File: rtl/step_tick_counter.sv
// rtl/step_tick_counter.sv - ramp pacing counter; flags a due step every STEP_DIV cycles
module step_tick_counter #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic due
);

    localparam int CNT_W = $clog2(STEP_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign due = (cnt_q == LAST);

    // Saturates at the terminal value so a stalled step stays due until released
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!hold && !due) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_volume_sequencer.sv
// rtl/dac_volume_sequencer.sv - ramps the DAC volume word toward the pot/mute target in bounded steps
module dac_volume_sequencer #(
    parameter int VOL_W    = synth_pkg::VOL_W,
    parameter int STEP_DIV = 4,
    parameter int STEP     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dac_ready,
    input  logic [VOL_W-1:0] target_volume,
    input  logic             mute,
    output logic [VOL_W-1:0] volume,
    output logic             vol_wr,
    output logic             busy,
    output logic             muted
);

    import synth_pkg::*;

    localparam logic [VOL_W-1:0] STEP_V = VOL_W'(STEP);

    seq_state_e       state_q, state_d;
    logic [VOL_W-1:0] volume_q, volume_d;
    logic             vol_wr_q, vol_wr_d;
    logic             busy_q, busy_d;

    logic             cnt_clear, cnt_hold, step_due;
    logic [VOL_W-1:0] tgt;
    logic [VOL_W:0]   diff;
    logic             dir_up;
    logic [VOL_W-1:0] mag, step_amt, next_vol;

    assign tgt = mute ? '0 : target_volume;

    // Sign bit of the widened difference gives the direction; magnitude never exceeds 2^VOL_W-1
    assign diff     = {1'b0, tgt} - {1'b0, volume_q};
    assign dir_up   = ~diff[VOL_W];
    assign mag      = dir_up ? diff[VOL_W-1:0] : -diff[VOL_W-1:0];
    assign step_amt = (mag < STEP_V) ? mag : STEP_V;
    assign next_vol = dir_up ? volume_q + step_amt : volume_q - step_amt;

    always_comb begin
        state_d   = state_q;
        volume_d  = volume_q;
        vol_wr_d  = 1'b0;
        cnt_clear = 1'b0;
        cnt_hold  = 1'b0;
        unique case (state_q)
            WAIT_DAC: begin
                cnt_clear = 1'b1;
                if (dac_ready) state_d = IDLE;
            end
            IDLE: begin
                cnt_clear = 1'b1;
                if (volume_q != tgt) state_d = RAMP;
            end
            RAMP: begin
                if (step_due) begin
                    if (volume_q == tgt) begin
                        cnt_clear = 1'b1;
                        state_d   = IDLE;
                    end else if (!dac_ready) begin
                        cnt_hold = 1'b1;
                    end else begin
                        cnt_clear = 1'b1;
                        volume_d  = next_vol;
                        vol_wr_d  = 1'b1;
                        if (next_vol == tgt) state_d = IDLE;
                    end
                end
            end
            default: begin
                cnt_clear = 1'b1;
                state_d   = WAIT_DAC;
            end
        endcase
        busy_d = (state_d == RAMP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WAIT_DAC;
            volume_q <= '0;
            vol_wr_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            volume_q <= volume_d;
            vol_wr_q <= vol_wr_d;
            busy_q   <= busy_d;
        end
    end

    step_tick_counter #(
        .STEP_DIV (STEP_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .hold  (cnt_hold),
        .due   (step_due)
    );

    assign volume = volume_q;
    assign vol_wr = vol_wr_q;
    assign busy   = busy_q;
    assign muted  = mute & (volume_q == '0);

endmodule

// File: tb/tb_dac_volume_sequencer.sv
// tb/tb_dac_volume_sequencer.sv - directed bench for dac_volume_sequencer with STEP=1 and STEP=5 instances
module tb_dac_volume_sequencer;

    localparam int STEP_DIV = 4;
    localparam int STEPS[2] = '{1, 5};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dac_ready = 1'b0;
    logic [6:0] target_volume = '0;
    logic       mute = 1'b0;

    logic [6:0] a_vol, b_vol;
    logic       a_wr, b_wr, a_busy, b_busy, a_muted, b_muted;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    dac_volume_sequencer #(.VOL_W(7), .STEP_DIV(STEP_DIV), .STEP(1)) dut_a (
        .clk(clk), .reset(reset), .dac_ready(dac_ready), .target_volume(target_volume),
        .mute(mute), .volume(a_vol), .vol_wr(a_wr), .busy(a_busy), .muted(a_muted)
    );

    dac_volume_sequencer #(.VOL_W(7), .STEP_DIV(STEP_DIV), .STEP(5)) dut_b (
        .clk(clk), .reset(reset), .dac_ready(dac_ready), .target_volume(target_volume),
        .mute(mute), .volume(b_vol), .vol_wr(b_wr), .busy(b_busy), .muted(b_muted)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: timestamp of the next due step instead of a tick counter
    int unsigned cyc = 0;
    int          m_vol[2]  = '{0, 0};
    bit          m_wr[2]   = '{0, 0};
    bit          m_act[2]  = '{0, 0};
    bit          m_seen[2] = '{0, 0};
    int unsigned m_due[2]  = '{0, 0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            automatic int          t   = mute ? 0 : int'(target_volume);
            automatic int          v   = m_vol[k];
            automatic int          nv  = v;
            automatic bit          wr  = 1'b0;
            automatic bit          act = m_act[k];
            automatic bit          sn  = m_seen[k];
            automatic int unsigned due = m_due[k];
            automatic int          d, s;
            if (reset) begin
                nv = 0; act = 1'b0; sn = 1'b0;
            end else if (!sn) begin
                sn = dac_ready;
            end else if (!act) begin
                if (v != t) begin
                    act = 1'b1;
                    due = cyc + STEP_DIV;
                end
            end else if (cyc >= due) begin
                if (v == t) begin
                    act = 1'b0;
                end else if (dac_ready) begin
                    d   = (t > v) ? t - v : v - t;
                    s   = (d < STEPS[k]) ? d : STEPS[k];
                    nv  = (t > v) ? v + s : v - s;
                    wr  = 1'b1;
                    due = cyc + STEP_DIV;
                    if (nv == t) act = 1'b0;
                end
            end
            m_vol[k]  <= nv;
            m_wr[k]   <= wr;
            m_act[k]  <= act;
            m_seen[k] <= sn;
            m_due[k]  <= due;
        end
        cyc <= cyc + 1;
    end

    logic [6:0] d_vol[2];
    logic       d_wr[2], d_busy[2], d_muted[2];
    bit         prev_wr[2] = '{0, 0};
    assign d_vol[0] = a_vol;   assign d_vol[1] = b_vol;
    assign d_wr[0] = a_wr;     assign d_wr[1] = b_wr;
    assign d_busy[0] = a_busy; assign d_busy[1] = b_busy;
    assign d_muted[0] = a_muted; assign d_muted[1] = b_muted;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("volume[%0d] cyc %0d", k, cyc), int'(d_vol[k]), m_vol[k]);
                chk($sformatf("vol_wr[%0d] cyc %0d", k, cyc), int'(d_wr[k]), int'(m_wr[k]));
                chk($sformatf("busy[%0d] cyc %0d", k, cyc), int'(d_busy[k]), int'(m_act[k]));
                chk($sformatf("muted[%0d] cyc %0d", k, cyc), int'(d_muted[k]),
                    int'(mute && (m_vol[k] == 0)));
                chk($sformatf("wr_back_to_back[%0d] cyc %0d", k, cyc), int'(prev_wr[k] && d_wr[k]), 0);
            end
        end
        prev_wr[0] = a_wr;
        prev_wr[1] = b_wr;
    end

    int qa[$];
    int qb[$];
    always @(negedge clk) begin
        if (a_wr) qa.push_back(int'(a_vol));
        if (b_wr) qb.push_back(int'(b_vol));
    end

    task automatic next_cycle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        qa.delete();
        qb.delete();
    endtask

    task automatic wait_idle(input string name, input int vol, input int budget);
        automatic bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            hit = (int'(a_vol) == vol) && !a_busy;
        end
        chk({name, " reached idle"}, int'(hit), 1);
        next_cycle(2);
    endtask

    task automatic wait_wr(input string name, input int vol, input int budget);
        automatic bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            hit = a_wr && (int'(a_vol) == vol);
        end
        chk({name, " write seen"}, int'(hit), 1);
        next_cycle(1);
    endtask

    task automatic check_log(input string name, input int got[$], input int exp[$]);
        chk({name, " count"}, got.size(), exp.size());
        if (got.size() == exp.size())
            foreach (exp[i]) chk($sformatf("%s[%0d]", name, i), got[i], exp[i]);
    endtask

    function automatic void ramp_list(output int q[$], input int from, input int to);
        q.delete();
        if (to >= from) for (int v = from; v <= to; v++) q.push_back(v);
        else            for (int v = from; v >= to; v--) q.push_back(v);
    endfunction

    initial begin
        automatic int exp_q[$];

        // Reset state, with mute held to observe the combinational muted flag
        mute = 1'b1;
        next_cycle(3);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset volume", int'(a_vol), 0);
        chk("reset vol_wr", int'(a_wr), 0);
        chk("reset busy", int'(a_busy), 0);
        chk("reset muted", int'(a_muted), 1);
        next_cycle(1);
        mute = 1'b0;

        // DAC not ready: nothing may be written
        reset = 1'b0;
        target_volume = 7'd20;
        clear_logs();
        next_cycle(50);
        chk("not_ready writes", qa.size() + qb.size(), 0);
        chk("not_ready volume", int'(a_vol), 0);
        dac_ready = 1'b1;
        wait_idle("ramp_up", 20, 200);
        ramp_list(exp_q, 1, 20);
        check_log("ramp_up_a", qa, exp_q);
        check_log("ramp_up_b", qb, '{5, 10, 15, 20});

        // Mute and release
        target_volume = 7'd10;
        wait_idle("down_to_10", 10, 200);
        clear_logs();
        mute = 1'b1;
        wait_idle("mute", 0, 200);
        ramp_list(exp_q, 9, 0);
        check_log("mute_a", qa, exp_q);
        chk("muted after 0", int'(a_muted), 1);
        clear_logs();
        mute = 1'b0;
        target_volume = 7'd20;
        wait_idle("unmute", 20, 200);
        ramp_list(exp_q, 1, 20);
        check_log("unmute_a", qa, exp_q);

        // Stall at volume 6, then reversal at 8
        target_volume = 7'd0;
        wait_idle("down_to_0", 0, 200);
        target_volume = 7'd30;
        wait_wr("reach_6", 6, 100);
        dac_ready = 1'b0;
        clear_logs();
        next_cycle(20);
        chk("stall writes", qa.size(), 0);
        chk("stall volume", int'(a_vol), 6);
        dac_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall release wr", int'(a_wr), 1);
        chk("stall release vol", int'(a_vol), 7);
        wait_wr("reach_8", 8, 20);
        clear_logs();
        target_volume = 7'd3;
        wait_idle("reversal", 3, 100);
        check_log("reversal_a", qa, '{7, 6, 5, 4, 3});

        // Reset mid-ramp, then restart from 0
        target_volume = 7'd30;
        wait_wr("reach_15", 15, 200);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midreset volume", int'(a_vol), 0);
        chk("midreset vol_wr", int'(a_wr), 0);
        chk("midreset busy", int'(a_busy), 0);
        next_cycle(1);
        reset = 1'b0;
        target_volume = 7'd12;
        clear_logs();
        wait_idle("restart", 12, 200);
        ramp_list(exp_q, 1, 12);
        check_log("restart_a", qa, exp_q);
        check_log("clamp_b", qb, '{5, 10, 12});
        chk("clamp_b idle", int'(b_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/dac_volume_sequencer.md
# dac_volume_sequencer

Controller that owns the 7-bit DAC volume word after power-up. It holds the DAC silent until the DAC interface reports ready, then ramps volume in bounded steps toward the pot-derived target, or toward zero when mute is requested. Each change is issued as a single-cycle write strobe to the DAC interface, so the DAC never sees an audible step. It sits between the reset/PLL sequencing logic and the DAC driver; its clock and reset come from the reset module's `clk`/`reset` outputs.

## Interface
- `VOL_W`, 7: volume word width.
- `STEP_DIV`, 4: clock cycles between ramp steps; legal range ≥ 2.
- `STEP`, 1: maximum volume change per step; legal range 1 to 2^VOL_W−1.
- `clk` input, 1: system clock.
- `reset` input, 1: synchronous reset, active-high.
- `dac_ready` input, 1: the DAC interface accepts writes while this is high.
- `target_volume` input, VOL_W: requested volume from the pot path; sampled every cycle.
- `mute` input, 1: level request to force the effective target to 0.
- `volume` output, VOL_W: current volume word; changes only in the cycle `vol_wr` is asserted.
- `vol_wr` output, 1: single-cycle strobe; `volume` is valid for the DAC in that cycle.
- `busy` output, 1: high in RAMP.
- `muted` output, 1: high when `mute=1` and `volume=0`.

## Operation
- Effective target `tgt` is `mute ? 0 : target_volume`. It is re-evaluated every cycle.
- States:
  - WAIT_DAC: entered on reset. Moves to IDLE when `dac_ready=1`.
  - IDLE: if `volume≠tgt`, moves to RAMP and clears the tick counter.
  - RAMP: when the tick counter reaches STEP_DIV−1 (step due), either stall or step:
    - If `dac_ready=0`: stall. The counter holds at its terminal value and no write occurs.
    - If `dac_ready=1`: step. `volume` moves toward `tgt` by min(STEP, |tgt−volume|), `vol_wr` pulses, and the counter clears.
    - After the step, if the new `volume` equals `tgt`, go to IDLE; otherwise stay in RAMP.
- Reversal:
  - Step direction is recomputed from `tgt` at each step, so a target change mid-ramp does not restart the counter.
  - If `tgt` equals `volume` when a step is due, no write occurs and the state goes to IDLE.
- Arithmetic:
  - Unsigned VOL_W-bit values; the difference is computed at VOL_W+1 bits.
  - `volume` never wraps and never overshoots `tgt`; it is clamped to the range 0..2^VOL_W−1.
- `dac_ready` low in IDLE: no effect. The block only writes in RAMP.
- `muted` is combinational on registered `volume` and `mute`.

## Timing
- Reset values: `volume=0`, `vol_wr=0`, `busy=0`, `muted=mute` (combinational), state WAIT_DAC, counter 0.
- `reset` has priority over all activity. With `reset=1` at an edge, all outputs take their reset values on that edge. This includes the case where a `vol_wr` would otherwise have fired.
- All outputs except `muted` are registered.
- Latency, target change in IDLE to first write: IDLE→RAMP takes 1 cycle, then STEP_DIV cycles, so the first `vol_wr` comes STEP_DIV+1 cycles after `tgt` changes.
- Write spacing: consecutive writes are exactly STEP_DIV cycles apart while `dac_ready` stays high.
- Stall release: a stalled step fires `vol_wr` on the first edge at which `dac_ready=1`.
- `vol_wr` is never asserted on two consecutive cycles.

## Structure
- Shared package `synth_pkg`: `VOL_W` constant and the state enum (WAIT_DAC, IDLE, RAMP).
- Sub-module `step_tick_counter`:
  - Parameter STEP_DIV.
  - Inputs: `clear`, `hold`.
  - Output: `due`.
  - Used by the sequencer FSM.

## Test plan
All scenarios use STEP_DIV=4 and STEP=1 unless stated.
- **DAC not ready:** reset, `dac_ready=0`, `target_volume=20` for 50 cycles → no `vol_wr`, `volume=0`. Then raise `dac_ready` → writes 1..20 spaced 4 cycles apart, then `busy=0`.
- **Mute and release:** assert `mute` when `volume=10` → writes 9..0; `muted=1` after the write of 0. Release `mute` → ramp back up to 20.
- **Step clamp:** STEP=5, ramp 0→12 → writes 5, 10, 12 only, then IDLE.
- **Stall:** drop `dac_ready` for 20 cycles mid-ramp at `volume=6` → no writes, `volume` held at 6. On the edge where `dac_ready` returns high → `vol_wr` with 7, then 4-cycle spacing resumes.
- **Reversal:** target 30 from 0; at `volume=8` change target to 3 → writes 7, 6, 5, 4, 3 with no overshoot.
- **Reset mid-ramp:** assert `reset` at `volume=15` → `volume=0`, `vol_wr=0` after that edge, state WAIT_DAC. Ramp restarts from 0 once `reset` is low and `dac_ready=1`.
